avalon_mm_mem_responder: RTL
============================

Name: avalon_mm_mem_responder

Overview:
- Avalon-MM slave that answers the requests issued by the custom master port: writes, reads, waitrequest and readdatavalid.
- Backed by an internal word memory. Wait states and read latency are programmable, so the master's stall and pipelined-read logic can be exercised.
- Used as the bus-side memory model in master-path benches, and as a simple on-chip scratch slave in the system.

Parameters:
ADDRESSWIDTH, 32, master byte-address width
DATAWIDTH, 32, data width (multiple of 8)
MEM_WORDS_LOG2, 9, log2 of memory depth in words
WAIT_CYCLES, 2, waitrequest cycles inserted before each command is accepted (0 = zero-wait)
READ_LATENCY, 2, cycles from read accept to readdatavalid (>=1)
MAX_PENDING, 4, maximum accepted-but-unreturned reads (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
address  in  ADDRESSWIDTH  byte address; word index = address[MEM_WORDS_LOG2+1:2]
write  in  1  write request
writedata  in  DATAWIDTH  write data
byteenable  in  DATAWIDTH/8  per-byte write enable
read  in  1  read request
readdata  out  DATAWIDTH  read return data
readdatavalid  out  1  readdata valid strobe, one cycle per read
waitrequest  out  1  stall; command held by master while high
write_count  out  16  count of accepted writes, wraps 16'hFFFF->0
addr_error  out  1  sticky: out-of-range access seen
proto_error  out  1  sticky: read and write asserted together

Behaviour:
- Reset (async assert, sync deassert by clk): readdatavalid=0, readdata=0, write_count=0, addr_error=0, proto_error=0, wait counter=0, read pipeline and pending count cleared.
- Memory contents are not reset. The pipeline is flushed, so a read in flight at reset never returns.
- Command present: cmd = read | write.
- waitrequest = cmd & ((wait_cnt != WAIT_CYCLES) | (read & ~write & pending == MAX_PENDING)). It is combinational from the inputs and state.
- wait_cnt rules:
  - increments each cycle cmd is high and waitrequest is high;
  - returns to 0 in the accept cycle (cmd & ~waitrequest);
  - returns to 0 if cmd drops without accept (master withdrew).
- Accepted command waits exactly WAIT_CYCLES cycles. Back-to-back commands each pay WAIT_CYCLES.
- Out-of-range access: address[ADDRESSWIDTH-1:MEM_WORDS_LOG2+2] != 0 sets addr_error.
  - Out-of-range write is discarded and still counted in write_count.
  - Out-of-range read returns 32'hDEADBEEF (low DATAWIDTH bits).
- Accepted write updates each memory byte whose byteenable bit is 1 at the clock edge ending the accept cycle. write_count increments.
- Accepted read:
  - samples memory in the accept cycle, so a write accepted in any earlier cycle is visible;
  - enters a READ_LATENCY-deep shift pipeline;
  - readdatavalid=1 with its data exactly READ_LATENCY cycles after the accept edge;
  - returns in accept order, never merged or dropped.
- readdata holds its last value when readdatavalid=0.
- pending: +1 on read accept, -1 on readdatavalid, both in one cycle leave it unchanged. Range 0..MAX_PENDING.
- When MAX_PENDING < READ_LATENCY, reads stall at pending==MAX_PENDING; a slot frees the cycle after readdatavalid.
- read & write together: proto_error set; treated as a write only (same wait and accept), and the read is ignored.
- Address, writedata and byteenable are sampled only in the accept cycle. Changes during waitrequest are not checked.

Test Plan:
- WAIT_CYCLES=0, READ_LATENCY=1: write 32'hA5A5_0001 to 0x10, then read 0x10 -> waitrequest never high; readdatavalid one cycle after the read accept with 32'hA5A5_0001; write_count=1.
- WAIT_CYCLES=2: hold write 3 cycles -> waitrequest high for cycles 1-2, accept in cycle 3.
- Same check repeated for 512 back-to-back writes to 0x000..0x7FC -> write_count=512, each pays 2 stalls.
- byteenable=4'b0101, writedata 32'h1122_3344 over a word holding 32'hFFFF_FFFF -> read returns 32'hFF22_FF44.
- READ_LATENCY=3, MAX_PENDING=2, 4 back-to-back zero-wait reads of 0x0,0x4,0x8,0xC -> 3rd read stalls until the first return; data arrives in order, exactly 3 cycles after each accept.
- Read 0x0000_0800 (MEM_WORDS_LOG2=9) -> readdata 32'hDEADBEEF, addr_error=1 until reset.
- Write discarded at the same address -> write_count still increments.
- read=write=1 at 0x20 with 32'h0000_0042 -> proto_error=1, no readdatavalid, later read of 0x20 returns 32'h42.
- Assert rst with 2 reads in flight -> readdatavalid stays 0, all outputs at reset values, memory data retained.

Source files
------------

// File: rtl/avalon_mm_mem_responder.sv
// avalon_mm_mem_responder: Avalon-MM memory slave with programmable wait states and pipelined read latency
module avalon_mm_mem_responder #(
    parameter int ADDRESSWIDTH   = 32,
    parameter int DATAWIDTH      = 32,
    parameter int MEM_WORDS_LOG2 = 9,
    parameter int WAIT_CYCLES    = 2,
    parameter int READ_LATENCY   = 2,
    parameter int MAX_PENDING    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDRESSWIDTH-1:0]   address,
    input  logic                      write,
    input  logic [DATAWIDTH-1:0]      writedata,
    input  logic [DATAWIDTH/8-1:0]    byteenable,
    input  logic                      read,
    output logic [DATAWIDTH-1:0]      readdata,
    output logic                      readdatavalid,
    output logic                      waitrequest,
    output logic [15:0]               write_count,
    output logic                      addr_error,
    output logic                      proto_error
);
    localparam int BE  = DATAWIDTH / 8;
    localparam int WCW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int PW  = $clog2(MAX_PENDING + 1);
    localparam logic [WCW-1:0] WMAX = WCW'(WAIT_CYCLES);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);
    localparam logic [DATAWIDTH-1:0] BAD = DATAWIDTH'(32'hDEADBEEF);

    logic [DATAWIDTH-1:0]      mem_q [2**MEM_WORDS_LOG2];
    logic [WCW-1:0]            wait_cnt_q, wait_cnt_d;
    logic [PW-1:0]             pend_q, pend_d;
    logic [READ_LATENCY-1:0]   vld_q;
    logic [DATAWIDTH-1:0]      dat_q [READ_LATENCY];
    logic [15:0]               wcount_q;
    logic                      addr_err_q, proto_err_q;
    logic                      cmd, is_rd, accept, rd_acc, wr_acc, oor;
    logic [MEM_WORDS_LOG2-1:0] widx;
    logic [DATAWIDTH-1:0]      rd_word;
    logic                      unused_ok;

    assign cmd         = read | write;
    assign is_rd       = read & ~write;
    assign waitrequest = cmd & ((wait_cnt_q != WMAX) | (is_rd & (pend_q == PMAX)));
    assign accept      = cmd & ~waitrequest;
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & is_rd;
    assign oor         = |address[ADDRESSWIDTH-1:MEM_WORDS_LOG2+2];
    assign widx        = address[MEM_WORDS_LOG2+1:2];
    assign rd_word     = oor ? BAD : mem_q[widx];
    assign unused_ok   = ^address[1:0];
    // Saturate at WAIT_CYCLES so a read held off by a full pending window stays accept-ready
    assign wait_cnt_d  = (!cmd || accept) ? '0 : (wait_cnt_q == WMAX ? wait_cnt_q : wait_cnt_q + WCW'(1));
    assign pend_d      = pend_q + PW'(rd_acc) - PW'(readdatavalid);

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];
    assign write_count   = wcount_q;
    assign addr_error    = addr_err_q;
    assign proto_error   = proto_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            pend_q      <= '0;
            vld_q       <= '0;
            dat_q       <= '{default: '0};
            wcount_q    <= '0;
            addr_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            pend_q      <= pend_d;
            vld_q       <= READ_LATENCY'({vld_q, rd_acc});
            dat_q[0]    <= rd_acc ? rd_word : dat_q[0];
            // Stages only advance with valid data so readdata holds between returns
            for (int i = 1; i < READ_LATENCY; i++)
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            wcount_q    <= wcount_q + 16'(wr_acc);
            addr_err_q  <= addr_err_q | (accept & oor);
            proto_err_q <= proto_err_q | (read & write);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !oor)
            for (int b = 0; b < BE; b++)
                if (byteenable[b]) mem_q[widx][8*b +: 8] <= writedata[8*b +: 8];
    end
endmodule
